// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: ID/EX stage with operand forwarding and a 2-entry skid buffer that feeds the 16-bit ALU
//   clk, reset           : single clock, synchronous active-high reset
//   flush                : synchronous pipeline kill (branch taken)
//   in_*                 : decoded instruction offered on the in_valid/in_ready handshake
//   exmem_*, memwb_*     : forwarding sources (EX/MEM has priority over MEM/WB)
//   out_valid/out_ready  : handshake toward EX for the head entry
//   input_A/B, ALU_Control, out_rd_addr, out_reg_write, out_store_data : registered head payload
//   stall_count          : present only when ID_EX_STALL_COUNT_EN is defined
module id_ex_alu_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs_addr,
  input  logic [REG_ADDR_W-1:0] in_rt_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_alu_op,
  input  logic                  in_reg_write,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     input_A,
  output logic [DATA_W-1:0]     input_B,
  output logic [2:0]            ALU_Control,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic [DATA_W-1:0]     out_store_data
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [DATA_W-1:0]     stall_count
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     st;
    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
  } entry_t;
  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic accept, consume;
  always_comb begin
    rs_fwd = (exmem_reg_write && exmem_rd_addr == in_rs_addr && in_rs_addr != '0) ? exmem_result :
             (memwb_reg_write && memwb_rd_addr == in_rs_addr && in_rs_addr != '0) ? memwb_result : in_rs_data;
    rt_fwd = (exmem_reg_write && exmem_rd_addr == in_rt_addr && in_rt_addr != '0) ? exmem_result :
             (memwb_reg_write && memwb_rd_addr == in_rt_addr && in_rt_addr != '0) ? memwb_result : in_rt_data;
    in_e = '{a: rs_fwd, b: in_use_imm ? in_imm : rt_fwd, st: rt_fwd, op: in_alu_op, rd: in_rd_addr, rw: in_reg_write};
  end
  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE ? ((accept && !consume) ? TWO : (!accept && consume) ? EMPTY : ONE) :
              (consume ? ONE : TWO);
  end
  // in_ready is a pure state decode, so out_ready never reaches it combinationally
  always_comb begin
    in_ready  = state_q != TWO;
    out_valid = state_q != EMPTY;
  end
  // a flushed accept is dropped; head keeps its last value so EMPTY outputs hold
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (!flush) begin
      if (state_q == TWO && consume) head_d = skid_q;
      else if (accept && (state_q == EMPTY || consume)) head_d = in_e;
      else if (accept && state_q == ONE) skid_d = in_e;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  assign input_A        = head_q.a;
  assign input_B        = head_q.b;
  assign ALU_Control    = head_q.op;
  assign out_rd_addr    = head_q.rd;
  assign out_reg_write  = head_q.rw;
  assign out_store_data = head_q.st;
`ifdef ID_EX_STALL_COUNT_EN
  logic [DATA_W-1:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// tb_id_ex_alu_stage: directed self-checking bench for id_ex_alu_stage
module tb_id_ex_alu_stage;
  logic clk = 0, reset, flush, in_valid, in_ready, in_use_imm, in_reg_write;
  logic [2:0] in_rs_addr, in_rt_addr, in_rd_addr, exmem_rd_addr, memwb_rd_addr, out_rd_addr;
  logic [15:0] in_rs_data, in_rt_data, in_imm, exmem_result, memwb_result;
  logic [2:0] in_alu_op, ALU_Control;
  logic exmem_reg_write, memwb_reg_write, out_valid, out_ready, out_reg_write;
  logic [15:0] input_A, input_B, out_store_data;
`ifdef ID_EX_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  id_ex_alu_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_alu_op(in_alu_op), .in_reg_write(in_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .input_A(input_A), .input_B(input_B),
    .ALU_Control(ALU_Control), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_store_data(out_store_data)
`ifdef ID_EX_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );
  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return a << b[3:0];
      3'd4: return a >> b[3:0];
      3'd5: return a & b;
      3'd6: return a | b;
      default: return {15'd0, $signed(a) < $signed(b)};
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                       input logic use_imm, input logic [2:0] op);
    in_valid = 1; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_use_imm = use_imm;
    in_alu_op = op; in_reg_write = 1;
  endtask
  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0; in_rs_data = 0; in_rt_data = 0;
    in_imm = 0; in_use_imm = 0; in_alu_op = 0; in_reg_write = 0;
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
    step(); step();
    reset = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_A", input_A, 0);
    chk("rst_B", input_B, 0);
    chk("rst_ctrl", ALU_Control, 0);
    chk("rst_store", out_store_data, 0);
    chk("rst_rw", out_reg_write, 0);
    step();
    chk("idle_out_valid", out_valid, 0);
    offer(1, 2, 4, 10, 20, 0, 0, 0);
    step();
    in_valid = 0;
    chk("add_valid", out_valid, 1);
    chk("add_A", input_A, 10);
    chk("add_B", input_B, 20);
    chk("add_ctrl", ALU_Control, 0);
    chk("add_rd", out_rd_addr, 4);
    chk("add_rw", out_reg_write, 1);
    chk("add_result", alu(input_A, input_B, ALU_Control), 30);
    step();
    chk("empty_valid", out_valid, 0);
    chk("empty_hold_A", input_A, 10);
    exmem_reg_write = 1; exmem_rd_addr = 3; exmem_result = 15;
    memwb_reg_write = 1; memwb_rd_addr = 3; memwb_result = 99;
    offer(3, 3, 5, 1, 2, 0, 0, 0);
    step();
    in_valid = 0;
    chk("fwd_exmem_A", input_A, 15);
    chk("fwd_exmem_B", input_B, 15);
    chk("fwd_exmem_st", out_store_data, 15);
    exmem_result = 16'h77;
    #1;
    chk("fwd_frozen_A", input_A, 15);
    exmem_reg_write = 0;
    offer(3, 3, 5, 1, 2, 0, 0, 0);
    step();
    in_valid = 0;
    chk("fwd_memwb_A", input_A, 99);
    chk("fwd_memwb_B", input_B, 99);
    exmem_reg_write = 1; exmem_rd_addr = 0; memwb_rd_addr = 0;
    offer(0, 0, 5, 1, 2, 0, 0, 0);
    step();
    in_valid = 0;
    chk("fwd_zero_A", input_A, 1);
    chk("fwd_zero_B", input_B, 2);
    exmem_reg_write = 0; memwb_reg_write = 0;
    offer(1, 2, 6, 15, 7, 10, 1, 1);
    step();
    in_valid = 0;
    chk("imm_A", input_A, 15);
    chk("imm_B", input_B, 10);
    chk("imm_ctrl", ALU_Control, 1);
    chk("imm_store", out_store_data, 7);
    step();
    chk("drain_valid", out_valid, 0);
    out_ready = 0;
    offer(1, 2, 1, 6, 2, 0, 0, 5);
    step();
    chk("bp1_in_ready", in_ready, 1);
    offer(1, 2, 2, 6, 2, 0, 0, 6);
    step();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_ctrl", ALU_Control, 5);
    offer(1, 2, 3, 4, 3, 0, 0, 7);
    step();
    chk("bp3_in_ready", in_ready, 0);
    chk("bp3_ctrl", ALU_Control, 5);
    chk("bp3_A", input_A, 6);
    chk("bp3_B", input_B, 2);
    out_ready = 1;
    step();
    chk("rel1_ctrl", ALU_Control, 6);
    chk("rel1_A", input_A, 6);
    chk("rel1_rd", out_rd_addr, 2);
    chk("rel1_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("rel2_ctrl", ALU_Control, 7);
    chk("rel2_A", input_A, 4);
    chk("rel2_B", input_B, 3);
    chk("rel2_result", alu(input_A, input_B, ALU_Control), 0);
    step();
    chk("rel_drain_valid", out_valid, 0);
`ifdef ID_EX_STALL_COUNT_EN
    chk("stall_count_bp", stall_count, 2);
`endif
    out_ready = 0;
    offer(1, 2, 1, 16'h1234, 1, 0, 0, 2);
    step();
    offer(1, 2, 2, 16'h5678, 1, 0, 0, 3);
    step();
    chk("fl_pre_in_ready", in_ready, 0);
    offer(1, 2, 3, 16'hBEEF, 1, 0, 0, 4);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_hold_A", input_A, 16'h1234);
    out_ready = 1;
    step(); step();
    chk("fl_never_valid", out_valid, 0);
`ifdef ID_EX_STALL_COUNT_EN
    chk("stall_count_flush", stall_count, 4);
`endif
    offer(1, 2, 7, 3, 1, 0, 0, 6);
    step();
    in_valid = 0;
    chk("post_fl_valid", out_valid, 1);
    chk("post_fl_ctrl", ALU_Control, 6);
    chk("post_fl_A", input_A, 3);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_alu_stage.md
Name: id_ex_alu_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the 16-bit ALU.
- Captures decoded operands, resolves EX/MEM and MEM/WB forwarding, and selects register or immediate for operand B.
- Presents registered input_A / input_B / ALU_Control to the ALU.
- Decouples decode from execute with a 2-entry skid buffer under a valid/ready handshake.

Parameters:
- DATA_W, 16, operand and result width.
- REG_ADDR_W, 3, register-file address width; address 0 is the hard-zero register.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous pipeline kill (branch taken).
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept.
- in_rs_addr  in  REG_ADDR_W  source A register.
- in_rt_addr  in  REG_ADDR_W  source B register.
- in_rd_addr  in  REG_ADDR_W  destination register.
- in_rs_data  in  DATA_W  register-file read A.
- in_rt_data  in  DATA_W  register-file read B.
- in_imm  in  DATA_W  immediate, already extended.
- in_use_imm  in  1  1 selects in_imm as operand B.
- in_alu_op  in  3  0 ADD, 1 SUB, 2 NOT, 3 LSL, 4 LSR, 5 AND, 6 OR, 7 SLT.
- in_reg_write  in  1  instruction writes rd.
- exmem_reg_write  in  1  EX/MEM forwarding enable.
- exmem_rd_addr  in  REG_ADDR_W  EX/MEM destination.
- exmem_result  in  DATA_W  EX/MEM value.
- memwb_reg_write  in  1  MEM/WB forwarding enable.
- memwb_rd_addr  in  REG_ADDR_W  MEM/WB destination.
- memwb_result  in  DATA_W  MEM/WB value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX consumes head entry.
- input_A  out  DATA_W  ALU operand A.
- input_B  out  DATA_W  ALU operand B.
- ALU_Control  out  3  ALU operation.
- out_rd_addr  out  REG_ADDR_W  destination passed downstream.
- out_reg_write  out  1  write enable passed downstream.
- out_store_data  out  DATA_W  forwarded rt value (for stores), independent of in_use_imm.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset (highest priority):
  - state EMPTY.
  - out_valid=0, in_ready=1.
  - All payload outputs (input_A, input_B, ALU_Control, out_rd_addr, out_reg_write, out_store_data) = 0.
  - Skid entry cleared.
- Forwarding is resolved combinationally at capture time, per source (rs, rt):
  - If exmem_reg_write && exmem_rd_addr==src && src!=0, use exmem_result.
  - Else if memwb_reg_write && memwb_rd_addr==src && src!=0, use memwb_result.
  - Else use register-file data.
  - A value is frozen once captured; later changes on forwarding ports do not alter buffered entries.
- Operand B = in_use_imm ? in_imm : forwarded rt. out_store_data = forwarded rt always.
- Handshake:
  - accept = in_valid && in_ready; consume = out_valid && out_ready.
  - Latency: accept in cycle N gives out_valid=1 in cycle N+1.
  - in_ready = (state != TWO). It is a registered state decode only; it has no combinational path from out_ready.
- States:
  - EMPTY:
    - accept -> ONE, head loaded.
    - otherwise stay.
  - ONE:
    - accept && consume -> ONE, head reloaded.
    - accept && !consume -> TWO, new entry into skid.
    - !accept && consume -> EMPTY.
    - else hold.
  - TWO:
    - consume -> ONE, skid moves to head.
    - else hold; no accept is possible.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Outputs are stable while out_valid && !out_ready.
- In EMPTY, payload outputs hold their last value and out_valid=0.
- Flush (below reset, above everything else):
  - next state EMPTY, out_valid=0, skid invalidated.
  - An accept in the same cycle is discarded.
  - A consume in the same cycle is still a valid transfer.
- No arithmetic is performed here; widths pass through unchanged, with no truncation or extension.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_count, DATA_W bits wide.
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release -> out_valid=0, in_ready=1, input_A=input_B=0, ALU_Control=0.
- Single ADD, rs_data=10, rt_data=20, alu_op=0, use_imm=0, out_ready=1 -> next cycle out_valid=1, input_A=10, input_B=20, ALU_Control=0, and 30 is observed on the attached ALU Result.
- Forwarding:
  - rs=3, rt=3, exmem (wr=1, rd=3, result=15) and memwb (wr=1, rd=3, result=99) -> input_A=15 and input_B=15 (EX/MEM wins).
  - Same case with rd=0 on both -> register-file values pass.
- Immediate SUB, rs_data=15, imm=10, use_imm=1, alu_op=1, rt_data=7 -> input_B=10, ALU_Control=1, out_store_data=7.
- Backpressure:
  - Hold out_ready=0, offer 3 back-to-back ops (AND 6/2, OR 6/2, SLT 4/3) -> first two accepted; in_ready=0 after the second.
  - Release out_ready -> outputs ALU_Control 5, 6, 7 in order with their operands, no loss.
  - With ID_EX_STALL_COUNT_EN, stall_count equals the number of stalled cycles.
- Flush in state TWO with simultaneous in_valid -> next cycle out_valid=0, in_ready=1; the offered instruction never appears at the output.
